// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with load extraction and write-back select for RegFile.
// Outputs are combinational from the stage registers; the retire counter counts departures.
module mem_wb_writeback #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               sys_clk,
  input  logic               rstn,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               in_valid,
  input  logic               in_reg_write,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic [1:0]         in_wb_sel,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    in_pc_plus4,
  input  logic [XLEN-1:0]    in_load_data,
  input  logic [2:0]         in_funct3,
  output logic [RADDR_W-1:0] WriteAddr,
  output logic [XLEN-1:0]    WriteData,
  output logic               RegWrite,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_addr,
  output logic [XLEN-1:0]    fwd_data,
  output logic               load_err,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  logic               r_valid;
  logic               r_reg_write;
  logic [RADDR_W-1:0] r_rd_addr;
  logic [1:0]         r_wb_sel;
  logic [XLEN-1:0]    r_alu_result;
  logic [XLEN-1:0]    r_pc_plus4;
  logic [XLEN-1:0]    r_load_data;
  logic [2:0]         r_funct3;
  logic [CNT_W-1:0]   r_retire_cnt;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd_addr    <= '0;
      r_wb_sel     <= '0;
      r_alu_result <= '0;
      r_pc_plus4   <= '0;
      r_load_data  <= '0;
      r_funct3     <= '0;
      r_retire_cnt <= '0;
    end else begin
      // A flushed instruction still departs the stage, so it counts unless stalled.
      if (r_valid && !stall_i)
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (flush_i) begin
        r_valid      <= 1'b0;
        r_reg_write  <= 1'b0;
        r_rd_addr    <= '0;
        r_wb_sel     <= '0;
        r_alu_result <= '0;
        r_pc_plus4   <= '0;
        r_load_data  <= '0;
        r_funct3     <= '0;
      end else if (!stall_i) begin
        r_valid      <= in_valid;
        r_reg_write  <= in_reg_write;
        r_rd_addr    <= in_rd_addr;
        r_wb_sel     <= in_wb_sel;
        r_alu_result <= in_alu_result;
        r_pc_plus4   <= in_pc_plus4;
        r_load_data  <= in_load_data;
        r_funct3     <= in_funct3;
      end
    end
  end

  logic [1:0]      w_a;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_val;
  logic            w_illegal;
  logic            w_misalign;
  logic            w_load_err;
  logic [XLEN-1:0] w_write_data;
  logic            w_reg_write;

  assign w_a    = r_alu_result[1:0];
  assign w_byte = r_load_data[{w_a, 3'b000} +: 8];
  assign w_half = w_a[1] ? r_load_data[31:16] : r_load_data[15:0];

  always_comb begin
    w_load_val = '0;
    case (r_funct3)
      3'b000:  w_load_val = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_val = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_val = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_val = {{(XLEN-16){1'b0}}, w_half};
      3'b010:  w_load_val = r_load_data;
      default: w_load_val = '0;
    endcase
  end

  assign w_illegal  = (r_funct3 == 3'b011) || (r_funct3 == 3'b110) || (r_funct3 == 3'b111);
  assign w_misalign = (((r_funct3 == 3'b001) || (r_funct3 == 3'b101)) && w_a[0])
                    || ((r_funct3 == 3'b010) && (w_a != 2'b00));
  assign w_load_err = r_valid && (r_wb_sel == SEL_LOAD) && (w_misalign || w_illegal);

  always_comb begin
    w_write_data = '0;
    case (r_wb_sel)
      SEL_ALU:  w_write_data = r_alu_result;
      SEL_LOAD: w_write_data = w_load_val;
      SEL_LINK: w_write_data = r_pc_plus4;
      default:  w_write_data = '0;
    endcase
  end

  // x0 is hard-wired zero, so writes to it are suppressed here rather than in RegFile.
  assign w_reg_write = r_valid && r_reg_write && (r_rd_addr != '0) && !w_load_err;

  assign WriteAddr  = r_rd_addr;
  assign WriteData  = w_write_data;
  assign RegWrite   = w_reg_write;
  assign fwd_valid  = w_reg_write;
  assign fwd_addr   = r_rd_addr;
  assign fwd_data   = w_write_data;
  assign load_err   = w_load_err;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed literal cases plus randomized traffic against a
// behavioural model of the stage; a second narrow-counter instance exercises counter wrap.
module tb_mem_wb_writeback;

  logic        sys_clk = 1'b0;
  logic        rstn;
  logic        stall_i, flush_i, in_valid, in_reg_write;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result, in_pc_plus4, in_load_data;
  logic [2:0]  in_funct3;

  logic [4:0]  WriteAddr, fwd_addr, wa4, fa4;
  logic [31:0] WriteData, fwd_data, wd4, fd4;
  logic        RegWrite, fwd_valid, load_err, rw4, fv4, le4;
  logic [31:0] retire_cnt;
  logic [3:0]  cnt4;

  always #5 sys_clk = ~sys_clk;

  mem_wb_writeback dut (
    .sys_clk(sys_clk), .rstn(rstn), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd_addr(in_rd_addr),
    .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_load_data(in_load_data), .in_funct3(in_funct3),
    .WriteAddr(WriteAddr), .WriteData(WriteData), .RegWrite(RegWrite),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .load_err(load_err), .retire_cnt(retire_cnt)
  );

  mem_wb_writeback #(.CNT_W(4)) dut4 (
    .sys_clk(sys_clk), .rstn(rstn), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd_addr(in_rd_addr),
    .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_load_data(in_load_data), .in_funct3(in_funct3),
    .WriteAddr(wa4), .WriteData(wd4), .RegWrite(rw4),
    .fwd_valid(fv4), .fwd_addr(fa4), .fwd_data(fd4),
    .load_err(le4), .retire_cnt(cnt4)
  );

  typedef struct {
    bit          v, rw;
    int unsigned rd, sel, f3, alu, pc, ld;
  } st_t;

  st_t         m;
  int unsigned m_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic int unsigned m_load(st_t s);
    int unsigned a, b, h;
    a = s.alu % 4;
    b = (s.ld >> (8 * a)) & 32'hFF;
    h = (s.ld >> (16 * (a / 2))) & 32'hFFFF;
    case (s.f3)
      0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      4: return b;
      1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      5: return h;
      2: return s.ld;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_illegal(st_t s);
    return (s.f3 == 3) || (s.f3 == 6) || (s.f3 == 7);
  endfunction

  function automatic bit m_err(st_t s);
    int unsigned a;
    a = s.alu % 4;
    if (!s.v || s.sel != 1) return 0;
    if ((s.f3 == 1 || s.f3 == 5) && (a % 2 == 1)) return 1;
    if (s.f3 == 2 && a != 0) return 1;
    return m_illegal(s);
  endfunction

  function automatic bit m_we(st_t s);
    return s.v && s.rw && (s.rd != 0) && !m_err(s);
  endfunction

  function automatic int unsigned m_wd(st_t s);
    case (s.sel)
      0: return s.alu;
      1: return m_load(s);
      2: return s.pc;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m = '{v: 0, rw: 0, rd: 0, sel: 0, f3: 0, alu: 0, pc: 0, ld: 0};
    m_cnt = 0;
  endtask

  task automatic compare_all();
    check("RegWrite", {31'd0, RegWrite}, {31'd0, m_we(m)});
    check("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_we(m)});
    check("WriteAddr", {27'd0, WriteAddr}, m.rd);
    check("fwd_addr", {27'd0, fwd_addr}, m.rd);
    check("load_err", {31'd0, load_err}, {31'd0, m_err(m)});
    if (!(m.sel == 1 && m_illegal(m))) begin
      check("WriteData", WriteData, m_wd(m));
      check("fwd_data", fwd_data, m_wd(m));
    end
    check("retire_cnt", retire_cnt, m_cnt);
    check("retire_cnt4", {28'd0, cnt4}, m_cnt % 16);
  endtask

  // Advance one edge: the model takes the same inputs the DUT sampled, then outputs are compared.
  task automatic tick();
    @(posedge sys_clk);
    if (rstn) begin
      if (m.v && !stall_i) m_cnt++;
      if (flush_i)
        m = '{v: 0, rw: 0, rd: 0, sel: 0, f3: 0, alu: 0, pc: 0, ld: 0};
      else if (!stall_i)
        m = '{v: in_valid, rw: in_reg_write, rd: in_rd_addr, sel: in_wb_sel, f3: in_funct3,
              alu: in_alu_result, pc: in_pc_plus4, ld: in_load_data};
    end
    #1;
    compare_all();
  endtask

  task automatic set_in(input bit v, input bit rw, input int unsigned rd, input int unsigned sel,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] ld,
                        input int unsigned f3);
    in_valid      = v;
    in_reg_write  = rw;
    in_rd_addr    = rd[4:0];
    in_wb_sel     = sel[1:0];
    in_alu_result = alu;
    in_pc_plus4   = pc;
    in_load_data  = ld;
    in_funct3     = f3[2:0];
  endtask

  typedef struct { int unsigned f3, a; logic [31:0] exp; } ld_t;
  ld_t ld_tab[6] = '{
    '{0, 0, 32'hFFFF_FF82}, '{4, 0, 32'h0000_0082}, '{0, 1, 32'h0000_007F},
    '{1, 2, 32'hFFFF_80F1}, '{5, 2, 32'h0000_80F1}, '{2, 0, 32'h80F1_7F82}
  };
  int unsigned bad_tab[3][2] = '{'{2, 2}, '{1, 1}, '{3, 0}};

  initial begin
    rstn = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst RegWrite", {31'd0, RegWrite}, 32'd0);
    check("rst WriteData", WriteData, 32'd0);
    check("rst retire_cnt", retire_cnt, 32'd0);
    rstn = 1'b1;

    // ALU write
    set_in(1, 1, 5, 0, 32'hDEAD_BEEF, 0, 0, 0);
    tick();
    check("alu RegWrite", {31'd0, RegWrite}, 32'd1);
    check("alu WriteAddr", {27'd0, WriteAddr}, 32'd5);
    check("alu WriteData", WriteData, 32'hDEAD_BEEF);
    check("alu cnt before", retire_cnt, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("alu cnt after", retire_cnt, 32'd1);

    foreach (ld_tab[i]) begin
      set_in(1, 1, 7, 1, ld_tab[i].a, 0, 32'h80F1_7F82, ld_tab[i].f3);
      tick();
      check($sformatf("load%0d WriteData", i), WriteData, ld_tab[i].exp);
      check($sformatf("load%0d model", i), m_load(m), ld_tab[i].exp);
      check($sformatf("load%0d RegWrite", i), {31'd0, RegWrite}, 32'd1);
    end

    foreach (bad_tab[i]) begin
      set_in(1, 1, 8, 1, bad_tab[i][1], 0, 32'h1234_5678, bad_tab[i][0]);
      tick();
      check($sformatf("bad%0d load_err", i), {31'd0, load_err}, 32'd1);
      check($sformatf("bad%0d RegWrite", i), {31'd0, RegWrite}, 32'd0);
    end

    set_in(1, 1, 0, 2, 0, 32'h104, 0, 0);
    tick();
    check("x0 RegWrite", {31'd0, RegWrite}, 32'd0);
    check("x0 WriteData", WriteData, 32'h0000_0104);
    check("x0 cnt", retire_cnt, 32'd10);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("x0 cnt after", retire_cnt, 32'd11);

    // Stall holds for three edges while the inputs move on
    set_in(1, 1, 9, 0, 32'h1234_5678, 0, 0, 0);
    tick();
    stall_i = 1'b1;
    set_in(1, 1, 10, 0, 32'hAAAA_5555, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall WriteAddr", {27'd0, WriteAddr}, 32'd9);
      check("stall WriteData", WriteData, 32'h1234_5678);
      check("stall RegWrite", {31'd0, RegWrite}, 32'd1);
      check("stall cnt", retire_cnt, 32'd11);
    end
    stall_i = 1'b0;
    tick();
    check("release WriteAddr", {27'd0, WriteAddr}, 32'd10);
    check("release cnt", retire_cnt, 32'd12);
    stall_i = 1'b1; flush_i = 1'b1;
    tick();
    check("stall+flush RegWrite", {31'd0, RegWrite}, 32'd0);
    check("stall+flush cnt", retire_cnt, 32'd12);
    stall_i = 1'b0; flush_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    check("flush RegWrite", {31'd0, RegWrite}, 32'd0);
    check("flush cnt", retire_cnt, 32'd13);
    flush_i = 1'b0;

    // Async reset between edges while a write is live
    set_in(1, 1, 3, 0, 32'h0BAD_F00D, 0, 0, 0);
    tick();
    #3 rstn = 1'b0;
    #1;
    check("arst RegWrite", {31'd0, RegWrite}, 32'd0);
    check("arst WriteData", WriteData, 32'd0);
    check("arst retire_cnt", retire_cnt, 32'd0);
    model_clear();
    #2 rstn = 1'b1;

    // Continuous retirement wraps the 4-bit counter
    set_in(1, 0, 1, 0, 0, 0, 0, 0);
    repeat (16) tick();
    check("wrap cnt4 pre", {28'd0, cnt4}, 32'd15);
    tick();
    check("wrap cnt4", {28'd0, cnt4}, 32'd0);
    check("wrap cnt32", retire_cnt, 32'd16);

    for (int c = 0; c < 3000; c++) begin
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31),
             $urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom_range(0, 7));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
